conv5_pool_reader: RTL and testbench

- Read-side controller for the 4x8 ping-pong buffer that sits between the second conv layer and the pooling stage.
- Waits for a bank (two rows x 8 columns) to be marked full by the writer, then reads it in 2x2 windows and computes the unsigned max of each window.
- Emits 4 pooled bytes per bank and hands the bank back to the writer.
- Sits between the conv-2 buffer RAM (1-cycle registered read) and the pooling-layer output buffer.

---
 rtl/conv5_pool_reader.sv | 184 ++++++++++++++++++
 tb/tb_conv5_pool_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv5_pool_reader.sv
// Read-side controller for the conv-2 ping-pong buffer: reads a full bank as
// 2x2 windows, emits the unsigned max of each window, then frees the bank.
module conv5_pool_reader #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 7,
  parameter int COLS       = 8,
  parameter int BANK1_BASE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bank_ready,
  input  logic              bank_sel,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] d_in,
  output logic              pool_valid,
  output logic [DATA_W-1:0] pool_out,
  output logic              pool_bank,
  output logic [1:0]        pool_col,
  output logic              bank_free,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [3:0]          k_q, k_d;
  logic                drain_q, drain_d;
  logic                cur_q, cur_d;
  logic                nxt_q, nxt_d;
  logic [1:0]          pend_q, pend_d;
  logic                overrun_q, overrun_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                start;
  logic                start_bank;

  // Read-return tracking: describes the d_in word arriving this cycle.
  logic                smp_vld_q;
  logic [3:0]          smp_k_q;
  logic                smp_bank_q;

  logic [DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]   win_max;
  logic                pool_valid_q;
  logic [DATA_W-1:0]   pool_out_q;
  logic                pool_bank_q;
  logic [1:0]          pool_col_q;
  logic                bank_free_q;

  // k = {window[1:0], row[0], col_lsb}
  function automatic logic [ADDR_W-1:0] addr_of(input logic bank, input logic [3:0] k);
    logic [ADDR_W-1:0] base;
    base = bank ? ADDR_W'(BANK1_BASE) : '0;
    return base + ADDR_W'(k[1]) * ADDR_W'(COLS) + ADDR_W'({k[3:2], 1'b0}) + ADDR_W'(k[0]);
  endfunction

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; a missing default in combinational logic infers a latch.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    drain_d    = drain_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    pend_d     = pend_q;
    overrun_d  = overrun_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    start      = 1'b0;
    start_bank = nxt_q;

    case (state_q)
      IDLE: begin
        if (pend_q[nxt_q]) begin
          start      = 1'b1;
          start_bank = nxt_q;
        end else if (pend_q[~nxt_q]) begin
          start      = 1'b1;
          start_bank = ~nxt_q;
        end
        if (start) begin
          state_d            = READ;
          k_d                = 4'd0;
          cur_d              = start_bank;
          nxt_d              = ~start_bank;
          pend_d[start_bank] = 1'b0;
          rd_en_d            = 1'b1;
          rd_addr_d          = addr_of(start_bank, 4'd0);
        end
      end
      READ: begin
        if (k_q == 4'd15) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          k_d       = k_q + 4'd1;
          rd_en_d   = 1'b1;
          rd_addr_d = addr_of(cur_q, k_q + 4'd1);
        end
      end
      DRAIN: begin
        if (drain_q) state_d = IDLE;
        else         drain_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A flag for a bank already pending or still in flight is an overrun;
    // that includes the bank being started this very cycle.
    if (bank_ready) begin
      if (pend_q[bank_sel] || ((state_q != IDLE) && (cur_q == bank_sel)))
        overrun_d = 1'b1;
      else
        pend_d[bank_sel] = 1'b1;
    end
  end

  always_comb begin
    win_max = (d_in > acc_q) ? d_in : acc_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: there is no storage array here, so every register, datapath
      // included, is reset; nothing can leak a partial window past reset.
      state_q      <= IDLE;
      k_q          <= 4'd0;
      drain_q      <= 1'b0;
      cur_q        <= 1'b0;
      nxt_q        <= 1'b0;
      pend_q       <= 2'b00;
      overrun_q    <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      smp_vld_q    <= 1'b0;
      smp_k_q      <= 4'd0;
      smp_bank_q   <= 1'b0;
      acc_q        <= '0;
      pool_valid_q <= 1'b0;
      pool_out_q   <= '0;
      pool_bank_q  <= 1'b0;
      pool_col_q   <= 2'd0;
      bank_free_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      drain_q      <= drain_d;
      cur_q        <= cur_d;
      nxt_q        <= nxt_d;
      pend_q       <= pend_d;
      overrun_q    <= overrun_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      smp_vld_q    <= rd_en_q;
      smp_k_q      <= k_q;
      smp_bank_q   <= cur_q;
      pool_valid_q <= 1'b0;
      bank_free_q  <= 1'b0;
      if (smp_vld_q) begin
        acc_q <= (smp_k_q[1:0] == 2'd0) ? d_in : win_max;
        if (smp_k_q[1:0] == 2'd3) begin
          pool_valid_q <= 1'b1;
          pool_out_q   <= win_max;
          pool_col_q   <= smp_k_q[3:2];
          pool_bank_q  <= smp_bank_q;
          bank_free_q  <= (smp_k_q[3:2] == 2'd3);
        end
      end
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign pool_valid = pool_valid_q;
  assign pool_out   = pool_out_q;
  assign pool_bank  = pool_bank_q;
  assign pool_col   = pool_col_q;
  assign bank_free  = bank_free_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_conv5_pool_reader.sv
// Self-checking bench for conv5_pool_reader: timestamp-based bank model,
// per-cycle compare, and directed scenarios with literal expectations.
module tb_conv5_pool_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       bank_ready;
  logic       bank_sel;
  logic       rd_en;
  logic [6:0] rd_addr;
  logic [7:0] d_in;
  logic       pool_valid;
  logic [7:0] pool_out;
  logic       pool_bank;
  logic [1:0] pool_col;
  logic       bank_free;
  logic       overrun;

  conv5_pool_reader #(.DATA_W(8), .ADDR_W(7), .COLS(8), .BANK1_BASE(16)) dut (
    .clk(clk), .rst(rst), .bank_ready(bank_ready), .bank_sel(bank_sel),
    .rd_en(rd_en), .rd_addr(rd_addr), .d_in(d_in),
    .pool_valid(pool_valid), .pool_out(pool_out), .pool_bank(pool_bank),
    .pool_col(pool_col), .bank_free(bank_free), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Buffer RAM with a one-cycle registered read.
  logic [7:0] mem [128];
  always @(posedge clk) d_in <= rd_en ? mem[rd_addr] : 8'h00;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int baddr(input bit b, input int w, input int p);
    return (b ? 16 : 0) + (p / 2) * 8 + 2 * w + (p % 2);
  endfunction

  function automatic int window_max(input bit b, input int w);
    int m;
    m = 0;
    for (int p = 0; p < 4; p++)
      if (int'(mem[baddr(b, w, p)]) > m) m = int'(mem[baddr(b, w, p)]);
    return m;
  endfunction

  // Model: a bank started at edge t0 owns cycles t0..t0+17; IDLE at t0+18.
  int  cyc = 0;
  bit  m_busy = 0;
  int  m_t0 = 0;
  bit  m_cur = 0, m_nxt = 0, m_ovr = 0;
  bit  [1:0] m_pend = 2'b00;
  int  m_pout = 0, m_pcol = 0;
  bit  m_pbank = 0;
  bit  s_rst, s_br, s_bs, idle_prev, reading_prev, cur_prev, started, sb;
  bit  [1:0] pend_prev;
  int  off;
  bit  exp_rd, exp_pv, exp_bf;
  int  n_valid = 0, n_rd = 0;
  int  addr_log[$];

  always @(posedge clk) begin
    s_rst = rst; s_br = bank_ready; s_bs = bank_sel;
    cyc++;
    if (s_rst) begin
      m_busy = 0; m_pend = 2'b00; m_nxt = 0; m_ovr = 0;
      m_pout = 0; m_pbank = 0; m_pcol = 0;
    end else begin
      idle_prev    = !m_busy || (cyc - 1 - m_t0 >= 18);
      reading_prev = !idle_prev;
      cur_prev     = m_cur;
      pend_prev    = m_pend;
      started      = 0;
      sb           = 0;
      if (idle_prev) begin
        m_busy = 0;
        if (pend_prev[m_nxt]) begin started = 1; sb = m_nxt; end
        else if (pend_prev[!m_nxt]) begin started = 1; sb = !m_nxt; end
        if (started) begin
          m_busy = 1; m_t0 = cyc; m_cur = sb; m_pend[sb] = 0; m_nxt = !sb;
        end
      end
      if (s_br) begin
        if (pend_prev[s_bs] || (reading_prev && cur_prev == s_bs)) m_ovr = 1;
        else m_pend[s_bs] = 1;
      end
    end
    off    = cyc - m_t0;
    exp_rd = m_busy && off >= 0 && off <= 15;
    exp_pv = m_busy && (off == 5 || off == 9 || off == 13 || off == 17);
    exp_bf = m_busy && off == 17;
    if (exp_pv) begin
      m_pcol  = (off - 5) / 4;
      m_pout  = window_max(m_cur, m_pcol);
      m_pbank = m_cur;
    end
    #1;
    check("rd_en", rd_en, exp_rd);
    if (exp_rd) check("rd_addr", rd_addr, baddr(m_cur, off / 4, off % 4));
    check("pool_valid", pool_valid, exp_pv);
    check("pool_out", pool_out, m_pout);
    check("pool_bank", pool_bank, m_pbank);
    check("pool_col", pool_col, m_pcol);
    check("bank_free", bank_free, exp_bf);
    check("overrun", overrun, m_ovr);
    if (pool_valid) n_valid++;
    if (rd_en) begin n_rd++; addr_log.push_back(int'(rd_addr)); end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit b);
    bank_ready = 1'b1; bank_sel = b;
    @(negedge clk);
    bank_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pv(input string name, input int e_out, input int e_col, input int e_bank);
    int t;
    t = 0;
    while (!pool_valid && t < 40) begin @(negedge clk); t++; end
    if (!pool_valid) check({name, " timeout"}, 0, 1);
    else begin
      check({name, " out"}, pool_out, e_out);
      check({name, " col"}, pool_col, e_col);
      check({name, " bank"}, pool_bank, e_bank);
      if (e_col == 3) check({name, " free"}, bank_free, 1);
    end
    @(negedge clk);
  endtask

  int exp_addr[16] = '{0, 1, 8, 9, 2, 3, 10, 11, 4, 5, 12, 13, 6, 7, 14, 15};

  initial begin
    rst = 1'b1; bank_ready = 1'b0; bank_sel = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
    mem[16] = 8'd255; mem[17] = 8'd0; mem[24] = 8'd0; mem[25] = 8'd0;
    mem[18] = 8'd3;   mem[19] = 8'd7; mem[26] = 8'd7; mem[27] = 8'd2;
    mem[20] = 8'd5;   mem[21] = 8'd6; mem[28] = 8'd4; mem[29] = 8'd1;
    mem[22] = 8'd9;   mem[23] = 8'd9; mem[30] = 8'd9; mem[31] = 8'd9;
    tick(2);
    rst = 1'b0;
    check("reset rd_en", rd_en, 0);
    check("reset pool_valid", pool_valid, 0);
    check("reset pool_out", pool_out, 0);
    check("reset overrun", overrun, 0);

    // Bank 0 ramp
    addr_log.delete();
    pulse(1'b0);
    wait_pv("s1 w0", 10, 0, 0);
    wait_pv("s1 w1", 12, 1, 0);
    wait_pv("s1 w2", 14, 2, 0);
    wait_pv("s1 w3", 16, 3, 0);
    tick(5);
    check("s1 read count", addr_log.size(), 16);
    for (int i = 0; i < 16 && i < addr_log.size(); i++)
      check("s1 addr order", addr_log[i], exp_addr[i]);

    // Bank 1: unsigned compare, ties
    pulse(1'b1);
    wait_pv("s2 w0", 255, 0, 1);
    wait_pv("s2 w1", 7, 1, 1);
    wait_pv("s2 w2", 6, 2, 1);
    wait_pv("s2 w3", 9, 3, 1);
    tick(5);

    // Back-to-back flags for both banks
    do_reset();
    n_valid = 0;
    bank_ready = 1'b1; bank_sel = 1'b1;
    @(negedge clk);
    bank_sel = 1'b0;
    @(negedge clk);
    bank_ready = 1'b0;
    tick(50);
    check("s3 outputs", n_valid, 8);

    // Double flag for bank 0 -> overrun, single read pass
    do_reset();
    n_rd = 0;
    bank_ready = 1'b1; bank_sel = 1'b0;
    tick(2);
    bank_ready = 1'b0;
    tick(30);
    check("s4 reads", n_rd, 16);
    check("s4 overrun", overrun, 1);
    tick(3);
    check("s4 overrun sticky", overrun, 1);
    do_reset();
    check("s4 overrun cleared", overrun, 0);

    // Reset mid-READ at k = 6
    pulse(1'b0);
    begin
      int t;
      t = 0;
      while (!rd_en && t < 10) begin @(negedge clk); t++; end
      check("s5 start", rd_en, 1);
    end
    tick(6);
    check("s5 k6 addr", rd_addr, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s5 rd_en after rst", rd_en, 0);
    check("s5 pool_valid after rst", pool_valid, 0);
    n_valid = 0;
    tick(20);
    check("s5 aborted outputs", n_valid, 0);
    pulse(1'b0);
    wait_pv("s5 w0", 10, 0, 0);
    wait_pv("s5 w1", 12, 1, 0);
    wait_pv("s5 w2", 14, 2, 0);
    wait_pv("s5 w3", 16, 3, 0);
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1);
  end

endmodule
